// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add unsigned multiplier with architectural HI/LO registers.
// It runs one multu in WIDTH cycles and handles the mthi/mtlo writes issued in IDLE.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]         state_q,  state_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [CW-1:0]      count_q,  count_d;
  logic [WIDTH-1:0]   hi_q,     hi_d;
  logic [WIDTH-1:0]   lo_q,     lo_d;
  logic               done_q,   done_d;
  logic [2*WIDTH-1:0] acc_next;

  // Next-state logic: operand capture, shift-add iteration, commit and HI/LO writes.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    acc_next = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

    case (state_q)
      S_IDLE: begin
        if (hi_we) begin
          hi_d = wdata;
        end else begin
          hi_d = hi_q;
        end
        if (lo_we) begin
          lo_d = wdata;
        end else begin
          lo_d = lo_q;
        end
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, src_a};
          mplier_d = src_b;
          acc_d    = {(2*WIDTH){1'b0}};
          count_d  = {CW{1'b0}};
          state_d  = S_BUSY;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_BUSY: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        // The final iteration commits straight from acc_next so HI/LO update atomically.
        if (count_q == LAST_CNT) begin
          {hi_d, lo_d} = acc_next;
          count_d      = {CW{1'b0}};
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end else begin
          count_d      = count_q + {{(CW-1){1'b0}}, 1'b1};
          state_d      = S_BUSY;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      count_q  <= {CW{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == S_BUSY);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mult_unit.md
# mult_unit

Iterative unsigned multiplier with architectural HI/LO registers: the execute-stage unit that carries out `multu` and serves `mfhi`/`mflo`/`mthi`/`mtlo` once the ALU decoder has classified the R-type function. It accepts one operand pair per issue and runs a radix-2 shift-add sequence for WIDTH cycles. It holds `busy` so the hazard logic can stall the pipeline, then commits the 2·WIDTH-bit product to HI/LO atomically.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are WIDTH bits each.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue `multu`; sampled only in IDLE.
- `src_a`  in  WIDTH  multiplicand (rs); sampled with `start`.
- `src_b`  in  WIDTH  multiplier (rt); sampled with `start`.
- `hi_we`  in  1  `mthi` write strobe.
- `lo_we`  in  1  `mtlo` write strobe.
- `wdata`  in  WIDTH  data for `mthi`/`mtlo`.
- `busy`  out  1  multiply in progress; the pipeline stalls any HI/LO access while this is high.
- `done`  out  1  one-cycle pulse; HI/LO hold the new product.
- `hi`  out  WIDTH  HI register (upper product half); `mfhi` source.
- `lo`  out  WIDTH  LO register (lower product half); `mflo` source.

## Operation
- States: IDLE, BUSY.
- In IDLE with `start`=1 at an edge:
  - `mcand` (2·WIDTH) is set to zero-extended `src_a`.
  - `mplier` (WIDTH) is set to `src_b`.
  - `acc` (2·WIDTH) is set to 0 and `count` is set to 0.
  - The state moves to BUSY.
- At each edge in BUSY:
  - `acc_next` = `acc` + (`mplier`[0] ? `mcand` : 0).
  - `mcand` shifts left 1 and `mplier` shifts right 1 (logical).
  - `count` increments.
- When `count` = WIDTH−1, that edge performs the last iteration and then:
  - {`hi`,`lo`} ← `acc_next`.
  - The state moves to IDLE and `done` is set.
- Arithmetic is unsigned modulo 2^(2·WIDTH). The product always fits, so no overflow occurs.
- `count` is ceil(log2(WIDTH)) bits and does not wrap within an operation.
- `start` while BUSY is ignored. Operands are not re-sampled and no second operation is queued.
- `hi_we`/`lo_we` in IDLE write `wdata` to the selected register at the edge. Both strobes together write both registers.
- `hi_we`/`lo_we` while BUSY are ignored; the pipeline must not issue them then.
- `start` together with `hi_we`/`lo_we` in IDLE: the write takes effect immediately and the multiply is accepted. The later commit overwrites both registers.
- `busy` = (state == BUSY). `hi`/`lo` keep their previous values throughout BUSY.
- `done` is registered: high for exactly the one cycle after the committing edge, low otherwise.

## Timing
- Reset (asynchronous, `rst_n`=0) forces:
  - state to IDLE.
  - `busy`, `done`, `hi`, `lo`, `acc`, `mcand`, `mplier`, `count` to 0.
- Reset is released synchronously to the clock in the system. The first accepted `start` is at the first edge with `rst_n`=1.
- Reset mid-operation aborts it: no commit, no `done`, `hi`=`lo`=0.
- Let E0 be the edge that accepts `start`.
  - `busy` is high from after E0 through E(WIDTH).
  - The commit happens at E(WIDTH).
  - `hi`/`lo` are valid and `done`=1 in the cycle after E(WIDTH).
  - Total latency is WIDTH edges; `busy` is high for WIDTH cycles.
- Back-to-back issue: `start` is accepted at the edge right after the committing edge, i.e. during the `done` cycle. There are no dead cycles.
- Reading `hi`/`lo` is combinational from the registers, with zero added latency.

## Test plan
- Basic multiply: reset, then `start` with `src_a`=3, `src_b`=5.
  - `busy` is high for exactly 32 cycles.
  - `done` pulses once, 32 edges after E0.
  - Result: `hi`=0, `lo`=15.
- Maximum operands: `src_a`=`src_b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Zero and power-of-two operands:
  - 0x80000000 × 2 → `hi`=1, `lo`=0.
  - 0 × 0x12345678 → `hi`=`lo`=0.
- `start` while BUSY: issue 7×9, then pulse `start` with 2×2 at cycle 5.
  - Result: `lo`=63.
  - Exactly one `done` pulse; `busy` stays low after the commit.
- HI/LO writes:
  - In IDLE, `hi_we` with `wdata`=0xDEADBEEF → `hi`=0xDEADBEEF at the next cycle.
  - During BUSY, `lo_we` with 0x1111 → ignored; `lo` stays unchanged until commit.
- Reset and back-to-back:
  - Drop `rst_n` at cycle 10 of a 6×6 multiply → `hi`=`lo`=0, `busy`=0, no `done`.
  - After the next commit, `start` 4×4 during the `done` cycle → accepted; `lo`=16 after 32 more edges.
